// File: rtl/rr_context_scheduler_if.sv
// Loader/fetch-side bundle of the round-robin context scheduler.
// master drives program set/halt and CPU status; slave is the scheduler.
interface rr_context_scheduler_if #(
    parameter int unsigned NUM_PROGS = 10,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned PC_W      = 32
);
    logic                 prog_set;
    logic [IDX_W-1:0]     prog_set_idx;
    logic [PC_W-1:0]      prog_set_pc;
    logic                 halt;
    logic [PC_W-1:0]      cpu_pc;
    logic                 cpu_safe;
    logic                 stall;
    logic                 pc_load;
    logic [PC_W-1:0]      pc_load_val;
    logic [IDX_W-1:0]     prog_index;
    logic                 running;
    logic [NUM_PROGS-1:0] runnable;

    modport master (
        output prog_set, prog_set_idx, prog_set_pc, halt, cpu_pc, cpu_safe,
        input  stall, pc_load, pc_load_val, prog_index, running, runnable
    );

    modport slave (
        input  prog_set, prog_set_idx, prog_set_pc, halt, cpu_pc, cpu_safe,
        output stall, pc_load, pc_load_val, prog_index, running, runnable
    );
endinterface

// File: rtl/rr_context_scheduler.sv
// Preemptive round-robin time-slice scheduler: per-program saved PC table,
// runnable mask, fixed quantum and a fetch-freezing context-switch sequence.
module rr_context_scheduler #(
    parameter int unsigned NUM_PROGS = 10,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned QUANTUM   = 64
) (
    input logic                   clock,
    input logic                   reset_n,
    rr_context_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(QUANTUM - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, SAVE, SELECT, LOAD} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_PROGS-1:0] runnable_q, runnable_d;
    logic [PC_W-1:0]      pc_table_q [NUM_PROGS];
    logic                 stall_q, running_q, pc_load_q;
    logic [PC_W-1:0]      pc_load_val_q;

    logic [NUM_PROGS-1:0] set_mask, cur_mask, halt_mask, others;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_PROGS) s = s - NUM_PROGS;
        return IDX_W'(s);
    endfunction

    // Out-of-range and already-runnable slots are dropped so saved PCs survive.
    always_comb begin : set_decode
        set_mask = '0;
        if (bus.prog_set && ({1'b0, bus.prog_set_idx} < (IDX_W+1)'(NUM_PROGS)))
            set_mask = NUM_PROGS'(1) << bus.prog_set_idx;
        set_mask   = set_mask & ~runnable_q;
        cur_mask   = NUM_PROGS'(1) << idx_q;
        halt_mask  = (state_q == RUN && bus.halt) ? cur_mask : '0;
        others     = runnable_q & ~cur_mask;
        runnable_d = (runnable_q | set_mask) & ~halt_mask;
    end

    // Rotating search from idx_q+1, ending at idx_q itself.
    always_comb begin : rr_search
        sel_found = 1'b0;
        sel_idx   = idx_q;
        for (int unsigned k = 1; k <= NUM_PROGS; k++) begin
            if (!sel_found && runnable_q[wrap_idx(idx_q, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(idx_q, k);
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|runnable_q) state_d = SELECT;
            RUN: begin
                if (bus.halt)                      state_d = SELECT;
                else if (cnt_q == '0 && |others)   state_d = DRAIN;
            end
            DRAIN:   if (bus.cpu_safe) state_d = SAVE;
            SAVE:    state_d = SELECT;
            SELECT:  state_d = sel_found ? LOAD : IDLE;
            LOAD:    state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin : fsm_reg
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            runnable_q    <= '0;
            stall_q       <= 1'b1;
            running_q     <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
        end else begin
            state_q    <= state_d;
            runnable_q <= runnable_d;
            stall_q    <= (state_d != RUN);
            running_q  <= (state_d != IDLE);
            pc_load_q  <= 1'b0;
            if (state_q == LOAD)
                cnt_q <= CNT_INIT;
            else if (state_q == RUN)
                cnt_q <= (cnt_q == '0) ? CNT_INIT : cnt_q - 1'b1;
            // The PC-load pulse coincides with the LOAD state.
            if (state_q == SELECT && sel_found) begin
                idx_q         <= sel_idx;
                pc_load_q     <= 1'b1;
                pc_load_val_q <= pc_table_q[sel_idx];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin : pc_table_reg
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_PROGS; i++) pc_table_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PROGS; i++) begin
                if (set_mask[i])
                    pc_table_q[i] <= bus.prog_set_pc;
                else if (state_q == SAVE && idx_q == IDX_W'(i))
                    pc_table_q[i] <= bus.cpu_pc;
            end
        end
    end

    assign bus.stall       = stall_q;
    assign bus.running     = running_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_load_val = pc_load_val_q;
    assign bus.prog_index  = idx_q;
    assign bus.runnable    = runnable_q;
endmodule

// File: doc/rr_context_scheduler.md
Name: rr_context_scheduler

Overview:
- Preemptive round-robin time-slice scheduler for the multiprogram processor.
- Holds a per-program saved-PC table and a runnable bitmask.
- Enforces a fixed quantum per program and sequences the context switch: freeze the fetch stage, wait for a safe boundary, save the outgoing PC, select the next program, then load its PC.
- Sits between the program loader (set/halt requests) and the processor fetch stage (stall/PC-load).

Parameters:
- NUM_PROGS, 10: number of program slots.
- IDX_W, 4: program index width; must satisfy 2^IDX_W >= NUM_PROGS.
- PC_W, 32: program counter width.
- QUANTUM, 64: RUN cycles granted per slice; must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- prog_set  in  1  mark prog_set_idx runnable, starting at prog_set_pc.
- prog_set_idx  in  IDX_W  slot to set.
- prog_set_pc  in  PC_W  start PC for that slot.
- halt  in  1  currently running program has finished; remove it from scheduling.
- cpu_pc  in  PC_W  processor PC of the next instruction to execute.
- cpu_safe  in  1  processor pipeline is drained; switching is allowed.
- stall  out  1  freeze instruction fetch.
- pc_load  out  1  one-cycle pulse: processor loads pc_load_val.
- pc_load_val  out  PC_W  PC to load.
- prog_index  out  IDX_W  current or last-run program.
- running  out  1  a program owns the processor.
- runnable  out  NUM_PROGS  runnable bitmask.

Behaviour:
Reset (async, reset_n=0):
- State IDLE, runnable=0, prog_index=0, pc_table all zero, quantum counter 0.
- stall=1, pc_load=0, pc_load_val=0, running=0.

State outputs:
- IDLE: stall=1, running=0.
- RUN: stall=0, running=1.
- DRAIN, SAVE, SELECT, LOAD: stall=1, running=1.

prog_set (accepted in any state):
- Ignored if prog_set_idx >= NUM_PROGS.
- Ignored if the slot is already runnable; its saved PC is not overwritten.
- Otherwise, at the next edge: runnable[idx]=1 and pc_table[idx]=prog_set_pc.

Transitions:
- IDLE -> SELECT when runnable != 0.
- RUN:
  - On entry, counter = QUANTUM-1. It decrements on every RUN cycle.
  - halt=1 -> clear runnable[prog_index], go to SELECT. The PC is not saved.
  - Else if counter==0 and another slot is runnable -> DRAIN.
  - Else if counter==0 and only the current slot is runnable -> reload counter to QUANTUM-1 and stay in RUN. No stall, no pc_load.
- DRAIN: hold until cpu_safe=1, then go to SAVE. halt is ignored outside RUN.
- SAVE: pc_table[prog_index] = cpu_pc, then go to SELECT. Lasts 1 cycle.
- SELECT (1 cycle):
  - Rotating search starting at prog_index+1, wrapping from NUM_PROGS-1 to 0, ending at prog_index itself. The first runnable slot is the next slot.
  - None found -> IDLE.
  - Otherwise -> LOAD.
- LOAD (1 cycle):
  - prog_index = next slot.
  - pc_load=1 and pc_load_val = pc_table[next slot].
  - Counter = QUANTUM-1, then go to RUN.
  - Applies even when the next slot equals the old one (halt/IDLE paths).

Latency and simultaneous events:
- Preemption path: cpu_safe seen in DRAIN -> SAVE -> SELECT -> LOAD -> RUN, i.e. 3 stalled cycles after DRAIN exits.
- prog_set and halt on the same slot in the same cycle: halt wins and the slot ends non-runnable.
- prog_set on a different slot in the same cycle as halt: both apply. The newly set slot is visible to the SELECT that follows.
- prog_set in SELECT's cycle is not visible to that search; it is considered at the next switch.
- Mid-operation reset returns immediately to the reset values; partially saved state is discarded.

Test Plan:
- Reset, then prog_set idx=3 pc=0x100 -> IDLE, SELECT, LOAD with pc_load=1, pc_load_val=0x100, prog_index=3; RUN with stall=0, running=1.
- Single program, QUANTUM=4, hold 12 cycles -> stall stays 0, no pc_load, prog_index stays 3.
- Programs 3 (pc 0x100) and 7 (pc 0x200), QUANTUM=4, cpu_pc=0x140 at expiry, cpu_safe delayed 2 cycles:
  - DRAIN lasts 3 cycles, then SAVE stores 0x140, then LOAD pc_load_val=0x200 with prog_index=7.
  - At the next expiry, LOAD pc_load_val=0x140 with prog_index=3.
- Wrap-around: runnable slots 1 and 9, running 9 -> next prog_index=1. Halt in slot 9 -> runnable=bit1 only, no SAVE, LOAD to 1.
- Halt of the last program -> SELECT, then IDLE with stall=1, running=0, runnable=0.
- Edge cases:
  - prog_set idx=12 -> ignored.
  - prog_set on already-runnable slot 7 with pc 0x999 -> pc_table[7] unchanged.
  - reset_n asserted mid-DRAIN -> all outputs return to reset values asynchronously, without waiting for a clock edge.
